// File: rtl/myo_spi_pkg.sv
// Shared constants and state encoding for the myo SPI slave.
// Build option: MYO_SPI_SLAVE_CHECKSUM_EN adds a ninth checksum word to every frame.
package myo_spi_pkg;

  localparam logic [15:0] MYO_SPI_HEADER    = 16'h8000;
  localparam int          MYO_SPI_WORD_BITS = 16;

`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
  localparam int MYO_SPI_FRAME_WORDS = 9;
`else
  localparam int MYO_SPI_FRAME_WORDS = 8;
`endif

  localparam int MYO_SPI_FRAME_BITS = MYO_SPI_FRAME_WORDS * MYO_SPI_WORD_BITS;
  localparam int MYO_SPI_CNT_W      = 8;

  // Word positions inside a frame
  localparam logic [3:0] MYO_SPI_WORD_HEADER   = 4'd0;
  localparam logic [3:0] MYO_SPI_WORD_PWM_REF  = 4'd1;
  localparam logic [3:0] MYO_SPI_WORD_CHECKSUM = 4'd8;

  // Frame FSM encoding
  typedef logic [1:0] myo_spi_state_t;
  localparam myo_spi_state_t ST_IDLE   = 2'd0;
  localparam myo_spi_state_t ST_ACTIVE = 2'd1;
  localparam myo_spi_state_t ST_CHECK  = 2'd2;

endpackage

// File: rtl/myo_spi_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect stage for one SPI pin.
// All stages reset to 0, so a line that is already low when reset releases
// produces no falling edge; a line that is high produces a rising edge, which
// the frame logic ignores while idle.
module myo_spi_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Shift the pin through the synchronizer and one history stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/myo_spi_slave.sv
// Motor-board SPI responder (CPOL=0, CPHA=1): receives the pwm reference and
// returns a coherent telemetry snapshot, oversampling the SPI pins in the
// system clock domain.
// Build option: MYO_SPI_SLAVE_CHECKSUM_EN appends/validates an XOR checksum word.
module myo_spi_slave
  import myo_spi_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 50_000_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic signed [31:0] position,
  input  logic signed [15:0] velocity,
  input  logic signed [15:0] current,
  input  logic        [15:0] displacement,
  input  logic signed [15:0] sensor1,
  input  logic signed [15:0] sensor2,
  output logic signed [15:0] pwm_ref,
  output logic               pwm_valid,
  output logic               frame_error
);

  localparam int FB = MYO_SPI_FRAME_BITS;
  localparam logic [MYO_SPI_CNT_W-1:0] FRAME_BITS_C = MYO_SPI_CNT_W'(FB);
  localparam logic [MYO_SPI_CNT_W-1:0] CNT_LIMIT    = MYO_SPI_CNT_W'(FB + 1);

  // The clock rate only bounds the usable sck rate (clock/8)
  if (CLOCK_SPEED_HZ <= 0) begin : g_clock_rate_guard
  end

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic mosi_meta, mosi_sync;

  myo_spi_sync_edge u_sck_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  myo_spi_sync_edge u_ss_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (ss_n),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  // mosi needs only a synchronizer; it lines up with the synchronized sck
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  myo_spi_state_t            state;
  logic [FB-1:0]             tx_frame, tx_shift;
  logic [MYO_SPI_CNT_W-1:0]  bit_cnt;
  logic [15:0]               rx_shift, rx_word, header_q, staging_q;
  logic [3:0]                word_idx;
  logic                      word_done, frame_ok;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
  logic [15:0]               rx_xor, rx_check;
`endif

  // Assemble the outgoing frame from the live telemetry
  always_comb begin
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    tx_frame = {16'h0000, position, velocity, current, displacement, sensor1, sensor2,
                position[31:16] ^ position[15:0] ^ velocity ^ current ^
                displacement ^ sensor1 ^ sensor2};
`else
    tx_frame = {16'h0000, position, velocity, current, displacement, sensor1, sensor2};
`endif
  end

  // Word completion and end-of-frame validity
  always_comb begin
    rx_word   = {rx_shift[14:0], mosi_sync};
    word_idx  = bit_cnt[7:4];
    word_done = (bit_cnt[3:0] == 4'hF) && (bit_cnt < FRAME_BITS_C);
    frame_ok  = (bit_cnt == FRAME_BITS_C) && (header_q == MYO_SPI_HEADER);
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
    frame_ok  = frame_ok && (rx_xor == rx_check);
`endif
  end

  // Frame FSM: snapshot on select, shift both directions, validate on deselect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      header_q    <= '0;
      staging_q   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      pwm_ref     <= '0;
      pwm_valid   <= 1'b0;
      frame_error <= 1'b0;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
      rx_xor      <= '0;
      rx_check    <= '0;
`endif
    end else begin
      pwm_valid   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (ss_fall) begin
            tx_shift  <= tx_frame;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            header_q  <= '0;
            staging_q <= '0;
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
            rx_xor    <= '0;
            rx_check  <= '0;
`endif
            miso_oe   <= 1'b1;
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            state   <= ST_CHECK;
          end else if (sck_rise) begin
            miso     <= tx_shift[FB-1];
            tx_shift <= {tx_shift[FB-2:0], 1'b0};
          end else if (sck_fall) begin
            rx_shift <= rx_word;
            if (bit_cnt != CNT_LIMIT) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (word_done) begin
              if (word_idx == MYO_SPI_WORD_HEADER) begin
                header_q <= rx_word;
              end
              if (word_idx == MYO_SPI_WORD_PWM_REF) begin
                staging_q <= rx_word;
              end
`ifdef MYO_SPI_SLAVE_CHECKSUM_EN
              if (word_idx < MYO_SPI_WORD_CHECKSUM) begin
                rx_xor <= rx_xor ^ rx_word;
              end else begin
                rx_check <= rx_word;
              end
`endif
            end
          end
        end
        ST_CHECK: begin
          pwm_valid   <= frame_ok;
          frame_error <= ~frame_ok;
          if (frame_ok) begin
            pwm_ref <= staging_q;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
